// File: rtl/ahb_burst_master_if.sv
// Command, write-FIFO, AHB and read-return signals of the burst master.
// The master modport is the DUT view; slave is the requester/bridge side.
interface ahb_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_pop;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [DATA_W-1:0] hwdata;
    logic              hreadyin;
    logic              hr_readyout;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data,
        input  hr_readyout, hresp, hrdata,
        output cmd_ready, wr_pop, haddr, htrans, hwrite, hwdata, hreadyin,
        output rd_valid, rd_data, done, err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data,
        output hr_readyout, hresp, hrdata,
        input  cmd_ready, wr_pop, haddr, htrans, hwrite, hwdata, hreadyin,
        input  rd_valid, rd_data, done, err
    );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns single/INCR commands into pipelined NONSEQ/SEQ
// transfers, restarting with NONSEQ at every 1KB boundary, and aborts on ERROR.
module ahb_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                hclk,
    input  logic                hresetn,
    ahb_burst_master_if.master  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST} state_e;
    typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11} htrans_e;

    state_e            r_state,     w_state_nxt;
    htrans_e           r_htrans,    w_htrans_nxt;
    logic [ADDR_W-1:0] r_haddr,     w_haddr_nxt;
    logic              r_hwrite,    w_hwrite_nxt;
    logic [DATA_W-1:0] r_hwdata,    w_hwdata_nxt;
    logic [LEN_W:0]    r_remain,    w_remain_nxt;
    logic              r_dphase,    w_dphase_nxt;
    logic              r_dphase_wr, w_dphase_wr_nxt;
    logic              r_rd_valid,  w_rd_valid_nxt;
    logic [DATA_W-1:0] r_rd_data,   w_rd_data_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_err,       w_err_nxt;

    logic              w_error;
    logic              w_dphase_done;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr_inc;

    // An ERROR response cancels whatever address phase overlaps it.
    assign w_error       = r_dphase && (bus.hresp == 2'b01);
    assign w_dphase_done = r_dphase && bus.hr_readyout;
    assign w_accept      = (r_htrans != TR_IDLE) && bus.hr_readyout && !w_error;
    assign w_addr_inc    = r_haddr + ADDR_W'(4);

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.wr_pop    = w_accept && r_hwrite && !hresetn;
    assign bus.hreadyin  = bus.hr_readyout;
    assign bus.haddr     = r_haddr;
    assign bus.htrans    = r_htrans;
    assign bus.hwrite    = r_hwrite;
    assign bus.hwdata    = r_hwdata;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt     = r_state;
        w_htrans_nxt    = r_htrans;
        w_haddr_nxt     = r_haddr;
        w_hwrite_nxt    = r_hwrite;
        w_hwdata_nxt    = r_hwdata;
        w_remain_nxt    = r_remain;
        w_dphase_nxt    = r_dphase;
        w_dphase_wr_nxt = r_dphase_wr;
        w_rd_valid_nxt  = 1'b0;
        w_rd_data_nxt   = r_rd_data;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_err;

        if (w_accept) begin
            w_dphase_nxt    = 1'b1;
            w_dphase_wr_nxt = r_hwrite;
            if (r_hwrite) begin
                w_hwdata_nxt = bus.wr_data;
            end
        end else if (w_dphase_done) begin
            w_dphase_nxt = 1'b0;
        end

        if (w_dphase_done && !r_dphase_wr && !w_error) begin
            w_rd_valid_nxt = 1'b1;
            w_rd_data_nxt  = bus.hrdata;
        end

        if (w_error) begin
            w_err_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_haddr_nxt  = {bus.cmd_addr[ADDR_W-1:2], 2'b00};
                    w_htrans_nxt = TR_NONSEQ;
                    w_hwrite_nxt = bus.cmd_write;
                    w_remain_nxt = {1'b0, bus.cmd_len};
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_error) begin
                    w_htrans_nxt = TR_IDLE;
                    if (w_dphase_done) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LAST;
                    end
                end else if (w_accept) begin
                    if (r_remain == '0) begin
                        w_htrans_nxt = TR_IDLE;
                        w_state_nxt  = ST_LAST;
                    end else begin
                        w_haddr_nxt  = w_addr_inc;
                        w_remain_nxt = r_remain - (LEN_W+1)'(1);
                        // A 1KB crossing (including the wrap to 0) must restart with NONSEQ.
                        w_htrans_nxt = (w_addr_inc[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                    end
                end
            end
            ST_LAST: begin
                if (w_dphase_done) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (hresetn) begin
            r_state     <= ST_IDLE;
            r_htrans    <= TR_IDLE;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_hwdata    <= '0;
            r_remain    <= '0;
            r_dphase    <= 1'b0;
            r_dphase_wr <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_htrans    <= w_htrans_nxt;
            r_haddr     <= w_haddr_nxt;
            r_hwrite    <= w_hwrite_nxt;
            r_hwdata    <= w_hwdata_nxt;
            r_remain    <= w_remain_nxt;
            r_dphase    <= w_dphase_nxt;
            r_dphase_wr <= w_dphase_wr_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_ahb_burst_master.sv
// Self-checking bench for ahb_burst_master: a scripted AHB responder, a
// beat/read-data model built from the command, and a per-cycle compare process.
module tb_ahb_burst_master;
    logic hclk = 1'b0;
    logic hresetn;

    ahb_burst_master_if bus_if ();

    ahb_burst_master dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus_if.master)
    );

    always #5 hclk = ~hclk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    bit          model_on = 1'b0;

    // Responder configuration, loaded when a command is handshaken.
    int          stall_beat_cfg = -1;
    int          stall_n_cfg    = 0;
    int          err_beat_cfg   = -1;
    logic [31:0] data_base      = 32'h0;

    // Responder state.
    bit          dp_valid = 1'b0;
    bit          dp_write = 1'b0;
    int          dp_idx   = 0;
    int          acc      = 0;
    int          pops     = 0;
    int          stall_left = 0;
    int          err_phase  = 0;
    bit          s_rst, s_start, s_acc, s_cmp, s_wr, s_pop;

    // Compare-process state.
    int          done_cnt    = 0;
    int          nonseq_cnt  = 0;
    int          rd_gap      = 0;
    int          last_rd_cyc = -1;
    int          cyc         = 0;
    bit          prev_stall  = 1'b0;
    bit          prev_err    = 1'b0;
    bit          prev_rst    = 1'b1;
    logic [31:0] prev_haddr;
    logic [1:0]  prev_htrans;
    logic [31:0] prev_hwdata;

    always @(posedge hclk) cyc++;

    // Bridge responder: OKAY by default, optional wait states on one beat,
    // and a two-cycle ERROR response on another.
    initial begin
        bus_if.hr_readyout = 1'b1;
        bus_if.hresp       = 2'b00;
        bus_if.hrdata      = 32'h0;
        bus_if.wr_data     = 32'h0;
        forever begin
            @(negedge hclk);
            s_rst   = hresetn;
            s_start = bus_if.cmd_valid && bus_if.cmd_ready;
            s_acc   = (bus_if.htrans != 2'b00) && bus_if.hr_readyout;
            s_cmp   = dp_valid && bus_if.hr_readyout;
            s_wr    = bus_if.hwrite;
            s_pop   = bus_if.wr_pop;
            @(posedge hclk);
            #1;
            if (s_rst) begin
                dp_valid = 1'b0;
            end else begin
                if (s_start) begin
                    acc        = 0;
                    pops       = 0;
                    stall_left = stall_n_cfg;
                    err_phase  = 0;
                end
                if (s_cmp) dp_valid = 1'b0;
                if (s_acc) begin
                    dp_valid = 1'b1;
                    dp_idx   = acc;
                    dp_write = s_wr;
                    acc++;
                end
                if (s_pop) pops++;
            end
            bus_if.wr_data     = data_base + 32'(pops);
            bus_if.hr_readyout = 1'b1;
            bus_if.hresp       = 2'b00;
            if (dp_valid) begin
                bus_if.hrdata = data_base + 32'(dp_idx);
                if (dp_idx == stall_beat_cfg && stall_left > 0) begin
                    bus_if.hr_readyout = 1'b0;
                    stall_left--;
                end else if (dp_idx == err_beat_cfg) begin
                    bus_if.hresp = 2'b01;
                    if (err_phase == 0) begin
                        bus_if.hr_readyout = 1'b0;
                        err_phase = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the command model.
    always @(negedge hclk) begin
        if (model_on && !hresetn) begin
            if (bus_if.cmd_valid && bus_if.cmd_ready) begin
                done_cnt    = 0;
                nonseq_cnt  = 0;
                rd_gap      = 0;
                last_rd_cyc = -1;
            end
            if (bus_if.htrans != 2'b00 && bus_if.hr_readyout) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("haddr", bus_if.haddr, b.addr);
                    check("htrans", bus_if.htrans, b.trans);
                    check("hwrite", bus_if.hwrite, b.wr);
                    if (bus_if.htrans == 2'b10) nonseq_cnt++;
                end
            end
            check("wr_pop", bus_if.wr_pop,
                  (bus_if.htrans != 2'b00) && bus_if.hr_readyout && bus_if.hwrite);
            check("hreadyin", bus_if.hreadyin, bus_if.hr_readyout);
            if (dp_valid && dp_write) check("hwdata", bus_if.hwdata, data_base + 32'(dp_idx));
            if (prev_stall && !prev_err && !prev_rst) begin
                check("haddr_hold", bus_if.haddr, prev_haddr);
                check("htrans_hold", bus_if.htrans, prev_htrans);
                check("hwdata_hold", bus_if.hwdata, prev_hwdata);
            end
            if (prev_err) check("htrans_after_err", bus_if.htrans, 2'b00);
            if (bus_if.rd_valid) begin
                if (exp_rd.size() == 0) check("unexpected_rd_valid", 1'b1, 1'b0);
                else check("rd_data", bus_if.rd_data, exp_rd.pop_front());
                if (last_rd_cyc >= 0 && cyc - last_rd_cyc != 1) rd_gap++;
                last_rd_cyc = cyc;
            end
            if (bus_if.done) done_cnt++;
        end
        prev_stall  = !bus_if.hr_readyout;
        prev_err    = dp_valid && (bus_if.hresp == 2'b01);
        prev_rst    = hresetn;
        prev_haddr  = bus_if.haddr;
        prev_htrans = bus_if.htrans;
        prev_hwdata = bus_if.hwdata;
    end

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input int sbeat, input int sn, input int ebeat,
                           input logic [31:0] base, output int lat);
        logic [31:0] a;
        int          n_acc;
        beat_t       b;
        bit          got;
        @(posedge hclk);
        #1;
        exp_beats.delete();
        exp_rd.delete();
        a     = {addr[31:2], 2'b00};
        n_acc = (ebeat >= 0 && ebeat <= int'(len)) ? ebeat + 1 : int'(len) + 1;
        for (int i = 0; i < n_acc; i++) begin
            b.addr  = a;
            b.trans = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
            b.wr    = wr;
            exp_beats.push_back(b);
            if (!wr && i != ebeat) exp_rd.push_back(base + 32'(i));
            a = a + 32'd4;
        end
        stall_beat_cfg = sbeat;
        stall_n_cfg    = sn;
        err_beat_cfg   = ebeat;
        data_base      = base;
        model_on       = 1'b1;
        check("cmd_ready_idle", bus_if.cmd_ready, 1'b1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_len   = len;
        @(posedge hclk);
        #1;
        bus_if.cmd_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 200 && !got; i++) begin
            @(negedge hclk);
            if (bus_if.done) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("done_seen", got, 1'b1);
        check("cmd_ready_with_done", bus_if.cmd_ready, 1'b1);
        repeat (2) @(negedge hclk);
        check("beats_left", exp_beats.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        check("done_count", done_cnt, 1);
        check("wr_pop_count", pops, wr ? n_acc : 0);
        check("err", bus_if.err, ebeat >= 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  found;
        int  dn;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 32'h0;
        bus_if.cmd_len   = 4'h0;
        hresetn = 1'b1;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("rst_htrans", bus_if.htrans, 2'b00);
        check("rst_haddr", bus_if.haddr, 32'h0);
        check("rst_hwrite", bus_if.hwrite, 1'b0);
        check("rst_hwdata", bus_if.hwdata, 32'h0);
        check("rst_wr_pop", bus_if.wr_pop, 1'b0);
        check("rst_rd_valid", bus_if.rd_valid, 1'b0);
        check("rst_rd_data", bus_if.rd_data, 32'h0);
        check("rst_done", bus_if.done, 1'b0);
        check("rst_err", bus_if.err, 1'b0);
        check("rst_cmd_ready", bus_if.cmd_ready, 1'b1);
        #1 hresetn = 1'b0;

        // Single zero-wait write.
        run_cmd(1'b1, 32'h8000_0000, 4'd0, -1, 0, -1, 32'hDEAD_BEEF, lat);
        check("t1_latency", lat, 3);
        check("t1_hwdata", bus_if.hwdata, 32'hDEAD_BEEF);
        check("t1_nonseq", nonseq_cnt, 1);

        // Four-beat read, no wait states.
        run_cmd(1'b0, 32'h8000_0010, 4'd3, -1, 0, -1, 32'h1, lat);
        check("t2_latency", lat, 6);
        check("t2_last_rd", bus_if.rd_data, 32'h4);
        check("t2_rd_gap", rd_gap, 0);
        check("t2_last_addr", bus_if.haddr, 32'h8000_001C);
        check("t2_nonseq", nonseq_cnt, 1);

        // Two-beat write with two wait states on beat 0.
        run_cmd(1'b1, 32'h8000_0100, 4'd1, 0, 2, -1, 32'h1111_0000, lat);
        check("t3_latency", lat, 6);
        check("t3_hwdata", bus_if.hwdata, 32'h1111_0001);

        // Three-beat read across a 1KB boundary.
        run_cmd(1'b0, 32'h8000_03FC, 4'd2, -1, 0, -1, 32'h100, lat);
        check("t4_nonseq", nonseq_cnt, 2);
        check("t4_last_addr", bus_if.haddr, 32'h8000_0404);
        check("t4_last_rd", bus_if.rd_data, 32'h102);

        // Five-beat write with ERROR on beat 1.
        run_cmd(1'b1, 32'h8000_0200, 4'd4, -1, 0, 1, 32'hA000_0000, lat);
        check("t5_latency", lat, 5);
        check("t5_err", bus_if.err, 1'b1);
        check("t5_hwdata", bus_if.hwdata, 32'hA000_0001);
        check("t5_cmd_ready", bus_if.cmd_ready, 1'b1);

        // Wrap from the top of memory; also clears the sticky err.
        run_cmd(1'b1, 32'hFFFF_FFFE, 4'd1, -1, 0, -1, 32'h5555_0000, lat);
        check("t7_nonseq", nonseq_cnt, 2);
        check("t7_last_addr", bus_if.haddr, 32'h0);
        check("t7_err_cleared", bus_if.err, 1'b0);

        // Reset during beat 2 of a four-beat read.
        model_on       = 1'b0;
        stall_beat_cfg = -1;
        err_beat_cfg   = -1;
        data_base      = 32'h0;
        @(posedge hclk);
        #1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 32'h8000_0040;
        bus_if.cmd_len   = 4'd3;
        @(posedge hclk);
        #1;
        bus_if.cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge hclk);
            if (bus_if.htrans != 2'b00 && bus_if.haddr == 32'h8000_0048) found = 1'b1;
        end
        check("t6_beat2_seen", found, 1'b1);
        #1 hresetn = 1'b1;
        @(posedge hclk);
        #1 hresetn = 1'b0;
        @(negedge hclk);
        check("t6_htrans", bus_if.htrans, 2'b00);
        check("t6_rd_valid", bus_if.rd_valid, 1'b0);
        check("t6_done", bus_if.done, 1'b0);
        check("t6_cmd_ready", bus_if.cmd_ready, 1'b1);
        check("t6_haddr", bus_if.haddr, 32'h0);
        dn = 0;
        repeat (5) begin
            @(negedge hclk);
            if (bus_if.done || bus_if.rd_valid || bus_if.htrans != 2'b00) dn++;
        end
        check("t6_quiet_after_reset", dn, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
- AHB-Lite master stage that sits directly upstream of bridge_top and drives its AHB slave port.
- Accepts single or INCR burst commands from a local command port and issues pipelined AHB transfers (NONSEQ/SEQ).
- Overlaps the address phase of beat n+1 with the data phase of beat n, and stalls on hr_readyout.
- Returns read data and a completion/error status to the requester.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (4-byte beats, address step 4).
- LEN_W, 4, burst length field width; a burst has cmd_len+1 beats (1..16).

Ports:
- hclk  in  1  bridge clock; all logic on rising edge.
- hresetn  in  1  synchronous, active-high reset (1 = reset), sampled on hclk.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; handshake on cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address; bits [1:0] ignored and forced to 0.
- cmd_len  in  LEN_W  beats minus one.
- wr_data  in  DATA_W  next write beat from the upstream FIFO; must be valid whenever wr_pop can assert.
- wr_pop  out  1  one-cycle pulse when wr_data is captured.
- haddr  out  ADDR_W  AHB address to bridge.
- htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ.
- hwrite  out  1  transfer direction.
- hwdata  out  DATA_W  write data, valid in the data phase.
- hreadyin  out  1  equals hr_readyout (feed-through to the bridge).
- hr_readyout  in  1  bridge ready; 0 = wait state.
- hresp  in  2  00 OKAY, 01 ERROR.
- hrdata  in  DATA_W  read data from bridge.
- rd_valid  out  1  pulse: rd_data holds one read beat.
- rd_data  out  DATA_W  registered hrdata.
- done  out  1  one-cycle pulse after the final data phase completes or aborts.
- err  out  1  sticky ERROR flag; cleared on the next command accept.

Behaviour:
- Reset (hresetn=1 at an edge) forces these values: state IDLE, htrans=00, haddr=0, hwrite=0, hwdata=0, wr_pop=0, rd_valid=0, rd_data=0, done=0, err=0, cmd_ready=1.
  - Reset mid-burst abandons the burst immediately; no done pulse is generated.
- "Beat accepted" means htrans≠00 and hr_readyout=1 at an edge (end of that beat's address phase).
- "Data phase complete" means hr_readyout=1 at an edge one or more cycles after acceptance.
- States:
  - IDLE: cmd_ready=1. On command accept, latch addr/len/write, clear err, set htrans=10 with haddr=cmd_addr and hwrite=cmd_write next cycle, go to ADDR.
  - ADDR: address phase active; all outputs held while hr_readyout=0.
    - On beat accept with beats remaining: haddr += 4, htrans=11 (SEQ).
    - If the new address has bits [9:0]=0 (1KB boundary crossed), htrans=10 (NONSEQ) instead.
    - On accept of the last beat: htrans=00 next cycle, go to LAST.
  - LAST: wait for the final data phase to complete; then done=1 for one cycle and go to IDLE. Zero idle cycles are inserted before cmd_ready rises.
- Write data:
  - When a write beat is accepted, wr_pop=1 that cycle and hwdata<=wr_data at the same edge.
  - hwdata is held until the next write acceptance.
- Read data:
  - When a read beat's data phase completes, rd_data<=hrdata and rd_valid=1 for one cycle.
  - Back-to-back beats with no wait states give rd_valid high on consecutive cycles.
- Latency: single zero-wait transfer gives command accept at T0, NONSEQ on T1, data phase T2, done/rd_valid asserted T3.
- Error:
  - On hresp=01 in a data phase, set err=1, drive htrans=00 next cycle, and suppress further wr_pop.
  - Wait for any outstanding accepted beat's data phase, pulse done, return to IDLE.
- Length counter: LEN_W+1 bits; cmd_len=0 yields exactly one NONSEQ and no SEQ.
- Address arithmetic is modulo 2^ADDR_W; wrap from 0xFFFFFFFC to 0 also counts as a boundary (NONSEQ).
- cmd_valid outside IDLE is ignored.

Test Plan:
- Single write, addr 0x8000_0000, wr_data 0xDEADBEEF, zero waits -> htrans 10 for one cycle, hwdata=0xDEADBEEF next cycle, one wr_pop, done at T3, err=0.
- Read burst len=3 at 0x8000_0010, hrdata 1..4 -> haddr 0x10,0x14,0x18,0x1C with htrans 10,11,11,11; rd_valid four consecutive cycles with data 1,2,3,4; done once.
- Write burst len=1 with hr_readyout low for 2 cycles on beat 0 -> haddr/htrans/hwdata stable during the stall; exactly 2 wr_pop total.
- Read burst len=2 starting 0x8000_03FC -> htrans 10 (0x3FC), 10 (0x400), 11 (0x404).
- Write burst len=4, hresp=01 on beat 1 data phase -> err=1, htrans=00 the following cycle, no further wr_pop, done pulses, cmd_ready=1 afterward.
- hresetn=1 during beat 2 of a 4-beat read -> next cycle htrans=00, rd_valid=0, done=0, cmd_ready=1.
